instruction_sequencer: RTL and testbench

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

---
 rtl/instruction_sequencer_if.sv | 24 ++
 rtl/instruction_sequencer.sv | 111 +++++++++++
 tb/tb_instruction_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Program-load / issue bus of the instruction sequencer.
interface instruction_sequencer_if;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [11:0] prog_data;
    logic        start;
    logic        hold;
    logic [3:0]  instruction;
    logic [7:0]  operand;
    logic        instr_valid;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output prog_we, prog_addr, prog_data, start, hold,
        input  instruction, operand, instr_valid, pc, busy, done, err
    );
    modport slave (
        input  prog_we, prog_addr, prog_data, start, hold,
        output instruction, operand, instr_valid, pc, busy, done, err
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: 16-entry program store issued one entry per cycle
// from address 0 until a HALT entry or the last entry. Every output is a flop;
// busy/done/issue outputs reflect the state of the previous cycle.
module instruction_sequencer #(
    parameter logic [3:0] HALT_CODE  = 4'hF,
    parameter logic [3:0] MAX_OPCODE = 4'd9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    instruction_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nx;
    logic [11:0] mem [16];
    logic [3:0]  pc_q, pc_nx;
    logic [3:0]  instr_q, instr_nx;
    logic [7:0]  opnd_q, opnd_nx;
    logic        vld_q, vld_nx;
    logic        busy_q, done_q;
    logic        err_q, err_nx;
    logic [3:0]  cur_op;
    logic [7:0]  cur_opnd;

    assign cur_op   = mem[pc_q][11:8];
    assign cur_opnd = mem[pc_q][7:0];

    // Program store: writable only while idle, contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && state == IDLE)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    // Next state, next pc and next issue word.
    always_comb begin
        state_nx = state;
        pc_nx    = pc_q;
        instr_nx = HALT_CODE;
        opnd_nx  = 8'h00;
        vld_nx   = 1'b0;
        err_nx   = err_q;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                    pc_nx    = 4'd0;
                    err_nx   = 1'b0;
                end
            end
            RUN: begin
                if (bus.prog_we)
                    err_nx = 1'b1;
                // hold freezes pc and postpones HALT detection
                if (!bus.hold) begin
                    if (cur_op == HALT_CODE) begin
                        state_nx = DONE;
                    end else begin
                        if (cur_op <= MAX_OPCODE) begin
                            instr_nx = cur_op;
                            opnd_nx  = cur_opnd;
                            vld_nx   = 1'b1;
                        end else begin
                            err_nx = 1'b1;
                        end
                        pc_nx = pc_q + 4'd1;
                        // consuming the last entry ends the run, no wrap
                        if (pc_q == 4'hF)
                            state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.prog_we)
                    err_nx = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc_q    <= 4'd0;
            instr_q <= HALT_CODE;
            opnd_q  <= 8'h00;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            pc_q    <= pc_nx;
            instr_q <= instr_nx;
            opnd_q  <= opnd_nx;
            vld_q   <= vld_nx;
            busy_q  <= (state != IDLE);
            done_q  <= (state == DONE);
            err_q   <= err_nx;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.operand     = opnd_q;
    assign bus.instr_valid = vld_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: a program model predicts the issue stream,
// which is queued at start and consumed as instr_valid beats appear.
module tb_instruction_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    instruction_sequencer_if bus();

    instruction_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [11:0] model [16];
    logic [11:0] q [$];
    logic        exp_err;
    logic [3:0]  exp_pc;
    int          exp_n;
    int          first_v, last_v, nvalid, done_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected issue stream of the current model program.
    task automatic build_expect();
        q.delete();
        exp_err = 1'b0;
        exp_pc  = 4'd0;
        exp_n   = 0;
        for (int i = 0; i < 16; i++) begin
            if (model[i][11:8] == 4'hF) begin
                exp_pc = 4'(i);
                break;
            end
            if (model[i][11:8] <= 4'd9) begin
                q.push_back(model[i]);
                exp_n++;
            end else begin
                exp_err = 1'b1;
            end
        end
    endtask

    // Scoreboard: every valid beat must match the head of the queue.
    always @(negedge clk) begin
        if (bus.instr_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_issue", {20'd0, bus.instruction, bus.operand}, 32'hFFFF_FFFF);
            end else begin
                chk("issue", {20'd0, bus.instruction, bus.operand}, {20'd0, q.pop_front()});
            end
        end
    end

    task automatic ld(input logic [3:0] a, input logic [11:0] d);
        @(posedge clk); #1;
        bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
        model[a] = d;
        @(posedge clk); #1;
        bus.prog_we = 1'b0;
    endtask

    task automatic run_prog(input int hold_at, input int hold_n, input int we_at,
                            input logic [3:0] wa, input logic [11:0] wd,
                            input bit wstart, input bit rel_rst);
        int c;
        logic [3:0] hold_pc;
        hold_pc = 4'd0;
        if (wstart) model[wa] = wd;
        build_expect();
        if (we_at >= 0) exp_err = 1'b1;
        @(posedge clk); #1;
        if (rel_rst) rst_n = 1'b1;
        bus.start = 1'b1;
        if (wstart) begin
            bus.prog_we = 1'b1; bus.prog_addr = wa; bus.prog_data = wd;
        end
        c = 0; first_v = -1; last_v = -1; nvalid = 0; done_c = -1;
        while (done_c < 0 && c < 60) begin
            @(negedge clk);
            if (bus.instr_valid) begin
                nvalid++;
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            chk("busy", {31'd0, bus.busy}, {31'd0, c >= 2});
            if (hold_n > 0 && c > hold_at && c <= hold_at + hold_n) begin
                chk("hold_vld", {31'd0, bus.instr_valid}, 32'd0);
                chk("hold_pc", {28'd0, bus.pc}, {28'd0, hold_pc});
            end
            if (c == hold_at) hold_pc = bus.pc;
            if (bus.done) done_c = c;
            @(posedge clk); #1;
            c++;
            bus.start = 1'b0;
            bus.prog_we = 1'b0;
            bus.hold = (hold_n > 0 && c >= hold_at && c < hold_at + hold_n);
            if (c == we_at) begin
                bus.prog_we = 1'b1; bus.prog_addr = wa; bus.prog_data = wd;
            end
        end
        bus.hold = 1'b0;
        bus.prog_we = 1'b0;
        if (done_c < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("sb_empty", q.size(), 32'd0);
        chk("err_end", {31'd0, bus.err}, {31'd0, exp_err});
        chk("pc_end", {28'd0, bus.pc}, {28'd0, exp_pc});
        chk("nvalid", nvalid, exp_n);
        if (exp_n > 0) chk("first_issue_cycle", first_v, 32'd2);
        @(negedge clk);
        chk("busy_after", {31'd0, bus.busy}, 32'd0);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.prog_we = 1'b0; bus.prog_addr = 4'd0; bus.prog_data = 12'd0;
        bus.start = 1'b0; bus.hold = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 12'hF00;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_instr", {28'd0, bus.instruction}, 32'hF);
        chk("rst_operand", {24'd0, bus.operand}, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_pc", {28'd0, bus.pc}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // basic program with exact cycle timing
        ld(4'd0, 12'h112); ld(4'd1, 12'h234); ld(4'd2, 12'h400); ld(4'd3, 12'hF00);
        run_prog(-1, 0, -1, 4'd0, 12'd0, 1'b0, 1'b0);
        chk("t1_done_cycle", done_c, 32'd6);
        chk("t1_last_issue", last_v, 32'd4);

        // two hold cycles after the first issue
        run_prog(2, 2, -1, 4'd0, 12'd0, 1'b0, 1'b0);
        chk("t2_done_cycle", done_c, 32'd8);
        chk("t2_last_issue", last_v, 32'd6);

        // asynchronous reset during the second issue, then re-run
        build_expect();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_instr", {28'd0, bus.instruction}, 32'hF);
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_pc", {28'd0, bus.pc}, 32'd0);
        q.delete();
        @(negedge clk);
        chk("mid_rst_hold_valid", {31'd0, bus.instr_valid}, 32'd0);
        run_prog(-1, 0, -1, 4'd0, 12'd0, 1'b0, 1'b1);
        chk("t3_done_cycle", done_c, 32'd6);

        // write attempt during run: err set, store unchanged
        run_prog(-1, 0, 3, 4'd1, 12'h399, 1'b0, 1'b0);
        run_prog(-1, 0, -1, 4'd0, 12'd0, 1'b0, 1'b0);

        // write to address 0 together with start is seen by first issue
        run_prog(-1, 0, -1, 4'd0, 12'h777, 1'b1, 1'b0);

        // illegal opcode in entry 1 is skipped
        ld(4'd0, 12'h112); ld(4'd1, 12'hB55); ld(4'd2, 12'h234); ld(4'd3, 12'hF00);
        run_prog(-1, 0, -1, 4'd0, 12'd0, 1'b0, 1'b0);
        chk("t6_done_cycle", done_c, 32'd6);

        // all sixteen entries legal: run ends at the last entry, pc wraps to 0
        for (int i = 0; i < 16; i++) ld(4'(i), {4'h5, 4'(i), 4'(15 - i)});
        run_prog(-1, 0, -1, 4'd0, 12'd0, 1'b0, 1'b0);
        chk("t7_last_issue", last_v, 32'd17);
        chk("t7_done_after_last", done_c, last_v + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
